add_seq_ctrl: RTL

- Multi-cycle wide add/subtract sequencer that time-shares a single cla_16 adder slice across NCHUNK 16-bit chunks, least significant chunk first.
- Registers the inter-chunk carry and assembles a W = 16*NCHUNK bit result.
- Sits beside the ALU as the wide-arithmetic unit and is driven by a start/done handshake from the execute stage.

---
 rtl/add_seq_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: multi-cycle wide add/subtract sequencer.
// A single 16-bit carry-lookahead slice (cla_16) is time-shared across
// NCHUNK chunks, least significant chunk first. The inter-chunk carry is
// registered, and the W = 16*NCHUNK bit result is assembled chunk by chunk.
//
// Optional build macro: ADDSEQ_ZERO_FLAG_EN adds a registered 'zero' flag
// that reports whether the whole result is zero.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   request, sampled when not busy
//   op_sub     in   0 = A+B, 1 = A-B (sampled with start)
//   operand_a  in   W-bit first operand (sampled with start)
//   operand_b  in   W-bit second operand (sampled with start)
//   busy       out  high while chunks are processed
//   done       out  one-cycle pulse, result/cout/ovf valid
//   result     out  W-bit sum/difference, held until next accept
//   cout       out  carry out of MSB chunk (subtract: 1 = no borrow)
//   ovf        out  signed overflow
//   zero       out  result == 0 (only with ADDSEQ_ZERO_FLAG_EN)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one chunk added per cycle, idx selects the chunk
// DONE  | done pulse; start here re-enters RUN without an idle cycle

module cla_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf
);
    logic [15:0] g, p;
    logic [3:0]  g4, p4;
    logic        cg, c1, c2, c3, c_msb, gg, pp;

    assign g = a & b;
    assign p = a ^ b;

    // Four 4-bit lookahead groups; group carries chain through cg.
    always_comb begin
        sum   = '0;
        cg    = cin;
        c_msb = 1'b0;
        g4    = '0;
        p4    = '0;
        c1    = 1'b0;
        c2    = 1'b0;
        c3    = 1'b0;
        gg    = 1'b0;
        pp    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            g4 = g[4*k +: 4];
            p4 = p[4*k +: 4];
            c1 = g4[0] | (p4[0] & cg);
            c2 = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cg);
            c3 = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
               | (p4[2] & p4[1] & p4[0] & cg);
            gg = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
               | (p4[3] & p4[2] & p4[1] & g4[0]);
            pp = &p4;
            sum[4*k +: 4] = p4 ^ {c3, c2, c1, cg};
            c_msb = c3;
            cg    = gg | (pp & cg);
        end
        cout = cg;
        ovf  = c_msb ^ cg;
    end
endmodule

module add_seq_ctrl #(
    parameter int NCHUNK = 4,
    localparam int W     = 16 * NCHUNK
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] operand_a,
    input  logic [W-1:0] operand_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
`ifdef ADDSEQ_ZERO_FLAG_EN
    ,
    output logic         zero
`endif
);
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic [W-1:0]   a_q, b_q;
    logic           carry_q;
    logic           load, last;
    logic [31:0]    base;
    logic [15:0]    sum;
    logic           slice_cout, slice_ovf;
`ifdef ADDSEQ_ZERO_FLAG_EN
    logic           sticky_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        load = start && (state_q != S_RUN);
        last = (state_q == S_RUN) && (idx_q == LAST_IDX);
    end

    assign base = 32'(idx_q) << 4;

    cla_16 u_cla (
        .a    (a_q[base +: 16]),
        .b    (b_q[base +: 16]),
        .cin  (carry_q),
        .sum  (sum),
        .cout (slice_cout),
        .ovf  (slice_ovf)
    );

    // Subtract is A + ~B + 1: invert B at load and seed the carry with 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
`ifdef ADDSEQ_ZERO_FLAG_EN
            sticky_q <= 1'b0;
            zero     <= 1'b0;
`endif
        end else if (load) begin
            a_q      <= operand_a;
            b_q      <= op_sub ? ~operand_b : operand_b;
            carry_q  <= op_sub;
            idx_q    <= '0;
`ifdef ADDSEQ_ZERO_FLAG_EN
            sticky_q <= 1'b0;
`endif
        end else if (busy) begin
            result[base +: 16] <= sum;
            carry_q  <= slice_cout;
            idx_q    <= idx_q + IW'(1);
`ifdef ADDSEQ_ZERO_FLAG_EN
            sticky_q <= sticky_q | (|sum);
`endif
            if (last) begin
                cout <= slice_cout;
                ovf  <= slice_ovf;
`ifdef ADDSEQ_ZERO_FLAG_EN
                zero <= ~(sticky_q | (|sum));
`endif
            end
        end
    end
endmodule
